// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared constants for the multi-cycle MIPS control unit:
//               opcodes, FSM state encoding, ALU operation codes, datapath
//               mux select encodings and opcode classification helpers.
// Ports       : (package - none)
// Revision    : 1.0 - initial multi-cycle release
// ============================================================================
package mips_ctrl_pkg;

    // Opcodes, instruction bits [31:26]
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    // FSM state encoding, visible on state_dbg
    localparam logic [3:0] c_ST_IDLE     = 4'd0;
    localparam logic [3:0] c_ST_FETCH    = 4'd1;
    localparam logic [3:0] c_ST_DECODE   = 4'd2;
    localparam logic [3:0] c_ST_EXEC     = 4'd3;
    localparam logic [3:0] c_ST_ALU_WB   = 4'd4;
    localparam logic [3:0] c_ST_MEM_ADDR = 4'd5;
    localparam logic [3:0] c_ST_MEM_RD   = 4'd6;
    localparam logic [3:0] c_ST_MEM_WB   = 4'd7;
    localparam logic [3:0] c_ST_MEM_WR   = 4'd8;
    localparam logic [3:0] c_ST_BRANCH   = 4'd9;
    localparam logic [3:0] c_ST_JUMP     = 4'd10;
    localparam logic [3:0] c_ST_ILLEGAL  = 4'd11;
    localparam logic [3:0] c_ST_BUS_ERR  = 4'd12;

    // ALU operation codes (zero-extended to ALUOP_W at the top level)
    localparam logic [2:0] c_ALU_R    = 3'b111;
    localparam logic [2:0] c_ALU_ADD  = 3'b100;
    localparam logic [2:0] c_ALU_ANDI = 3'b101;
    localparam logic [2:0] c_ALU_ORI  = 3'b110;
    localparam logic [2:0] c_ALU_LUI  = 3'b011;
    localparam logic [2:0] c_ALU_SUB  = 3'b001;

    // reg_dst selects
    localparam logic [1:0] c_RD_RT = 2'b00;
    localparam logic [1:0] c_RD_RD = 2'b01;
    localparam logic [1:0] c_RD_RA = 2'b10;

    // mem_to_reg selects
    localparam logic [1:0] c_M2R_ALUOUT = 2'b00;
    localparam logic [1:0] c_M2R_MDR    = 2'b01;
    localparam logic [1:0] c_M2R_PC     = 2'b10;

    // alu_src_b selects
    localparam logic [1:0] c_SRCB_B       = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR    = 2'b01;
    localparam logic [1:0] c_SRCB_IMM     = 2'b10;
    localparam logic [1:0] c_SRCB_IMM_SH2 = 2'b11;

    // pc_source selects
    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

    // Coarse instruction classes used by the DECODE dispatch
    typedef enum logic [2:0] {
        c_CLS_ALU     = 3'd0,
        c_CLS_MEM     = 3'd1,
        c_CLS_BRANCH  = 3'd2,
        c_CLS_JUMP    = 3'd3,
        c_CLS_ILLEGAL = 3'd4
    } op_class_e;

    function automatic op_class_e classifyOp(input logic [5:0] opcode,
                                             input logic       enableJal);
        op_class_e cls;
        case (opcode)
            c_OP_RTYPE, c_OP_ADDI, c_OP_ANDI,
            c_OP_ORI, c_OP_LUI:           cls = c_CLS_ALU;
            c_OP_LW, c_OP_SW:             cls = c_CLS_MEM;
            c_OP_BEQ, c_OP_BNE:           cls = c_CLS_BRANCH;
            c_OP_J:                       cls = c_CLS_JUMP;
            c_OP_JAL:                     cls = enableJal ? c_CLS_JUMP : c_CLS_ILLEGAL;
            default:                      cls = c_CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    // ALU code for the EXEC state of an ALU-class instruction
    function automatic logic [2:0] aluCodeFor(input logic [5:0] opcode);
        logic [2:0] code;
        case (opcode)
            c_OP_RTYPE: code = c_ALU_R;
            c_OP_ANDI:  code = c_ALU_ANDI;
            c_OP_ORI:   code = c_ALU_ORI;
            c_OP_LUI:   code = c_ALU_LUI;
            default:    code = c_ALU_ADD;   // ADDI
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_timer
// Description : Counts cycles spent waiting for mem_ready and flags when the
//               wait has reached MEM_TIMEOUT. MEM_TIMEOUT = 0 disables it.
// Ports       : clk      - system clock, rising edge
//               rst      - synchronous active-high reset, clears the count
//               clear    - restart the count (entry into a wait state)
//               count_en - one more wait cycle elapsed
//               expired  - count has reached MEM_TIMEOUT
// Revision    : 1.0 - initial multi-cycle release
// ============================================================================
module mem_wait_timer #(
    parameter int CNT_W       = 8,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    generate
        if (MEM_TIMEOUT != 0) begin : g_timeout_on
            localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(MEM_TIMEOUT);

            logic [CNT_W-1:0] r_count;

            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    r_count <= '0;
                end else if (count_en) begin
                    r_count <= r_count + 1'b1;
                end
            end

            assign expired = (r_count == c_LIMIT);
        end else begin : g_timeout_off
            logic w_unusedInputs;
            assign w_unusedInputs = clk ^ rst ^ clear ^ count_en;
            assign expired        = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Moore control FSM for a multi-cycle MIPS datapath sharing one
//               instruction/data memory. Sequences FETCH/DECODE/EXECUTE/
//               MEMORY/WRITEBACK for R-type, ADDI/ANDI/ORI/LUI, LW, SW,
//               BEQ, BNE, J and JAL, with memory timeout and illegal-opcode
//               reporting.
// Ports       : clk, reset             - clock / synchronous active-high reset
//               op                     - opcode from the instruction register
//               mem_ready              - memory completes access this cycle
//               pc_write, pc_write_eq,
//               pc_write_ne            - PC load enables
//               iord, mem_read,
//               mem_write, ir_write    - memory / IR control
//               reg_dst, mem_to_reg,
//               reg_write              - register file control
//               alu_src_a, alu_src_b,
//               pc_source, alu_op      - ALU / PC mux control
//               illegal_op, bus_error  - one-cycle error pulses
//               state_dbg              - current state encoding
// Revision    : 1.0 - initial multi-cycle release
// ============================================================================
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8,
    parameter int ENABLE_JAL  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_eq,
    output logic               pc_write_ne,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_source,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               illegal_op,
    output logic               bus_error,
    output logic [3:0]         state_dbg
);

    logic [3:0] r_state;
    logic [3:0] w_nextState;
    logic [5:0] r_opQ;
    logic [2:0] w_aluSel;
    logic       w_waitState;
    logic       w_nextIsWait;
    logic       w_timerClear;
    logic       w_timerCount;
    logic       w_timerExpired;
    op_class_e  w_decodeClass;

    // ------------------------------------------------------------------
    // Memory wait timer: restarts whenever a wait state is freshly entered
    // and advances for every cycle the memory holds mem_ready low.
    // ------------------------------------------------------------------
    assign w_waitState  = (r_state == c_ST_FETCH) || (r_state == c_ST_MEM_RD) ||
                          (r_state == c_ST_MEM_WR);
    assign w_nextIsWait = (w_nextState == c_ST_FETCH) || (w_nextState == c_ST_MEM_RD) ||
                          (w_nextState == c_ST_MEM_WR);
    assign w_timerClear = w_nextIsWait && (w_nextState != r_state);
    assign w_timerCount = w_waitState && !mem_ready;

    mem_wait_timer #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_memWaitTimer (
        .clk      (clk),
        .rst      (reset),
        .clear    (w_timerClear),
        .count_en (w_timerCount),
        .expired  (w_timerExpired)
    );

    // DECODE dispatches on the live opcode; op_q is only valid afterwards.
    assign w_decodeClass = classifyOp(op, ENABLE_JAL != 0);

    // ------------------------------------------------------------------
    // State and opcode registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_opQ   <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == c_ST_DECODE) begin
                r_opQ <= op;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. In the wait states mem_ready takes priority over
    // an expiring timeout.
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState = c_ST_IDLE;
        case (r_state)
            c_ST_IDLE:     w_nextState = c_ST_FETCH;
            c_ST_FETCH: begin
                if (mem_ready)           w_nextState = c_ST_DECODE;
                else if (w_timerExpired) w_nextState = c_ST_BUS_ERR;
                else                     w_nextState = c_ST_FETCH;
            end
            c_ST_DECODE: begin
                case (w_decodeClass)
                    c_CLS_ALU:    w_nextState = c_ST_EXEC;
                    c_CLS_MEM:    w_nextState = c_ST_MEM_ADDR;
                    c_CLS_BRANCH: w_nextState = c_ST_BRANCH;
                    c_CLS_JUMP:   w_nextState = c_ST_JUMP;
                    default:      w_nextState = c_ST_ILLEGAL;
                endcase
            end
            c_ST_EXEC:     w_nextState = c_ST_ALU_WB;
            c_ST_MEM_ADDR: w_nextState = (r_opQ == c_OP_LW) ? c_ST_MEM_RD : c_ST_MEM_WR;
            c_ST_MEM_RD: begin
                if (mem_ready)           w_nextState = c_ST_MEM_WB;
                else if (w_timerExpired) w_nextState = c_ST_BUS_ERR;
                else                     w_nextState = c_ST_MEM_RD;
            end
            c_ST_MEM_WR: begin
                if (mem_ready)           w_nextState = c_ST_FETCH;
                else if (w_timerExpired) w_nextState = c_ST_BUS_ERR;
                else                     w_nextState = c_ST_MEM_WR;
            end
            c_ST_ALU_WB, c_ST_MEM_WB, c_ST_BRANCH, c_ST_JUMP,
            c_ST_ILLEGAL, c_ST_BUS_ERR:
                           w_nextState = c_ST_FETCH;
            default:       w_nextState = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode. Everything is a function of state and op_q except
    // ir_write/pc_write in FETCH, which fire only on the completing cycle.
    // ------------------------------------------------------------------
    always_comb begin
        pc_write    = 1'b0;
        pc_write_eq = 1'b0;
        pc_write_ne = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = c_RD_RT;
        mem_to_reg  = c_M2R_ALUOUT;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = c_SRCB_B;
        pc_source   = c_PCSRC_ALU;
        w_aluSel    = 3'b000;
        illegal_op  = 1'b0;
        bus_error   = 1'b0;
        case (r_state)
            c_ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = c_SRCB_FOUR;
                w_aluSel  = c_ALU_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            c_ST_DECODE: begin
                // Speculative branch target into ALUOut
                alu_src_b = c_SRCB_IMM_SH2;
                w_aluSel  = c_ALU_ADD;
            end
            c_ST_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = (r_opQ == c_OP_RTYPE) ? c_SRCB_B : c_SRCB_IMM;
                w_aluSel  = aluCodeFor(r_opQ);
            end
            c_ST_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = (r_opQ == c_OP_RTYPE) ? c_RD_RD : c_RD_RT;
            end
            c_ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = c_SRCB_IMM;
                w_aluSel  = c_ALU_ADD;
            end
            c_ST_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            c_ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = c_M2R_MDR;
            end
            c_ST_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            c_ST_BRANCH: begin
                alu_src_a   = 1'b1;
                w_aluSel    = c_ALU_SUB;
                pc_source   = c_PCSRC_ALUOUT;
                pc_write_eq = (r_opQ == c_OP_BEQ);
                pc_write_ne = (r_opQ == c_OP_BNE);
            end
            c_ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = c_PCSRC_JUMP;
                // Link: PC already holds PC+4 from FETCH
                if (r_opQ == c_OP_JAL) begin
                    reg_write  = 1'b1;
                    reg_dst    = c_RD_RA;
                    mem_to_reg = c_M2R_PC;
                end
            end
            c_ST_ILLEGAL: illegal_op = 1'b1;
            c_ST_BUS_ERR: bus_error  = 1'b1;
            default: ;
        endcase
    end

    assign alu_op    = ALUOP_W'(w_aluSel);
    assign state_dbg = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Self-checking bench for multicycle_control. Two instances
//               (JAL enabled / disabled) run the same stimulus; a queue of
//               expected per-cycle control words is built from the
//               instruction-level behaviour and compared every cycle.
// Revision    : 1.0 - initial multi-cycle release
// ============================================================================
module tb_multicycle_control;

    localparam int TMO = 16;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    typedef struct packed {
        logic [3:0] st;
        logic       pcW, pcEq, pcNe, iord, mRd, mWr, irW;
        logic [1:0] regDst, m2r;
        logic       regW, srcA;
        logic [1:0] srcB, pcSrc;
        logic [2:0] aluOp;
        logic       ill, busErr;
    } ctrl_t;

    typedef struct packed {
        logic  rdy;
        ctrl_t exp;
        ctrl_t expNj;
    } step_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       mem_ready;
    logic [5:0] op;

    always #5 clk = ~clk;

    logic       pcWJ, pcEqJ, pcNeJ, iordJ, mRdJ, mWrJ, irWJ, regWJ, srcAJ, illJ, beJ;
    logic [1:0] regDstJ, m2rJ, srcBJ, pcSrcJ;
    logic [2:0] aluOpJ;
    logic [3:0] stJ;
    logic       pcWN, pcEqN, pcNeN, iordN, mRdN, mWrN, irWN, regWN, srcAN, illN, beN;
    logic [1:0] regDstN, m2rN, srcBN, pcSrcN;
    logic [2:0] aluOpN;
    logic [3:0] stN;

    multicycle_control #(.ALUOP_W(3), .MEM_TIMEOUT(TMO), .CNT_W(8), .ENABLE_JAL(1)) dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .pc_write(pcWJ), .pc_write_eq(pcEqJ), .pc_write_ne(pcNeJ), .iord(iordJ),
        .mem_read(mRdJ), .mem_write(mWrJ), .ir_write(irWJ), .reg_dst(regDstJ),
        .mem_to_reg(m2rJ), .reg_write(regWJ), .alu_src_a(srcAJ), .alu_src_b(srcBJ),
        .pc_source(pcSrcJ), .alu_op(aluOpJ), .illegal_op(illJ), .bus_error(beJ),
        .state_dbg(stJ)
    );

    multicycle_control #(.ALUOP_W(3), .MEM_TIMEOUT(TMO), .CNT_W(8), .ENABLE_JAL(0)) dutNoJal (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .pc_write(pcWN), .pc_write_eq(pcEqN), .pc_write_ne(pcNeN), .iord(iordN),
        .mem_read(mRdN), .mem_write(mWrN), .ir_write(irWN), .reg_dst(regDstN),
        .mem_to_reg(m2rN), .reg_write(regWN), .alu_src_a(srcAN), .alu_src_b(srcBN),
        .pc_source(pcSrcN), .alu_op(aluOpN), .illegal_op(illN), .bus_error(beN),
        .state_dbg(stN)
    );

    ctrl_t obsJ, obsN;
    assign obsJ = {stJ, pcWJ, pcEqJ, pcNeJ, iordJ, mRdJ, mWrJ, irWJ, regDstJ, m2rJ,
                   regWJ, srcAJ, srcBJ, pcSrcJ, aluOpJ, illJ, beJ};
    assign obsN = {stN, pcWN, pcEqN, pcNeN, iordN, mRdN, mWrN, irWN, regDstN, m2rN,
                   regWN, srcAN, srcBN, pcSrcN, aluOpN, illN, beN};

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    step_t q[$];

    // ---------------- reference model: expected control words ----------
    function automatic ctrl_t w0(input logic [3:0] st);
        ctrl_t c;
        c    = '0;
        c.st = st;
        return c;
    endfunction

    function automatic ctrl_t fetchW(input logic rdy);
        ctrl_t c;
        c       = w0(4'd1);
        c.mRd   = 1'b1;
        c.srcB  = 2'b01;
        c.aluOp = 3'b100;
        c.irW   = rdy;
        c.pcW   = rdy;
        return c;
    endfunction

    function automatic ctrl_t memW(input logic isRead);
        ctrl_t c;
        c      = w0(isRead ? 4'd6 : 4'd8);
        c.mRd  = isRead;
        c.mWr  = !isRead;
        c.iord = 1'b1;
        return c;
    endfunction

    function automatic logic [2:0] expAlu(input logic [5:0] opc);
        case (opc)
            OP_R:    return 3'b111;
            OP_ANDI: return 3'b101;
            OP_ORI:  return 3'b110;
            OP_LUI:  return 3'b011;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic rdy, input ctrl_t e, input ctrl_t enj);
        step_t s;
        s.rdy   = rdy;
        s.exp   = e;
        s.expNj = enj;
        q.push_back(s);
    endtask

    task automatic push1(input logic rdy, input ctrl_t e);
        push(rdy, e, e);
    endtask

    // A wait phase of 'waits' idle memory cycles; beyond TMO waits the access
    // is abandoned after TMO+1 low cycles.
    task automatic waitPhase(input ctrl_t lowW, input ctrl_t doneW, input int waits,
                             output bit aborted);
        int n;
        aborted = (waits > TMO);
        n       = aborted ? TMO + 1 : waits;
        for (int i = 0; i < n; i++) push1(1'b0, lowW);
        if (!aborted) push1(1'b1, doneW);
    endtask

    task automatic buildInstr(input logic [5:0] opc, input int fw, input int mw);
        ctrl_t c, cn;
        bit    ab;
        waitPhase(fetchW(1'b0), fetchW(1'b1), fw, ab);
        if (ab) begin
            c        = w0(4'd12);
            c.busErr = 1'b1;
            push1(rnd1(), c);
            push1(1'b1, fetchW(1'b1));    // retry at the same PC
        end
        c       = w0(4'd2);
        c.srcB  = 2'b11;
        c.aluOp = 3'b100;
        push1(rnd1(), c);
        case (opc)
            OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: begin
                c       = w0(4'd3);
                c.srcA  = 1'b1;
                c.srcB  = (opc == OP_R) ? 2'b00 : 2'b10;
                c.aluOp = expAlu(opc);
                push1(rnd1(), c);
                c        = w0(4'd4);
                c.regW   = 1'b1;
                c.regDst = (opc == OP_R) ? 2'b01 : 2'b00;
                push1(rnd1(), c);
            end
            OP_LW, OP_SW: begin
                c       = w0(4'd5);
                c.srcA  = 1'b1;
                c.srcB  = 2'b10;
                c.aluOp = 3'b100;
                push1(rnd1(), c);
                waitPhase(memW(opc == OP_LW), memW(opc == OP_LW), mw, ab);
                if (ab) begin
                    c        = w0(4'd12);
                    c.busErr = 1'b1;
                    push1(rnd1(), c);
                end else if (opc == OP_LW) begin
                    c      = w0(4'd7);
                    c.regW = 1'b1;
                    c.m2r  = 2'b01;
                    push1(rnd1(), c);
                end
            end
            OP_BEQ, OP_BNE: begin
                c       = w0(4'd9);
                c.srcA  = 1'b1;
                c.aluOp = 3'b001;
                c.pcSrc = 2'b01;
                c.pcEq  = (opc == OP_BEQ);
                c.pcNe  = (opc == OP_BNE);
                push1(rnd1(), c);
            end
            OP_J, OP_JAL: begin
                c       = w0(4'd10);
                c.pcW   = 1'b1;
                c.pcSrc = 2'b10;
                if (opc == OP_JAL) begin
                    c.regW   = 1'b1;
                    c.regDst = 2'b10;
                    c.m2r    = 2'b10;
                    cn       = w0(4'd11);
                    cn.ill   = 1'b1;
                    push(rnd1(), c, cn);
                end else begin
                    push1(rnd1(), c);
                end
            end
            default: begin
                c     = w0(4'd11);
                c.ill = 1'b1;
                push1(rnd1(), c);
            end
        endcase
    endtask

    // ---------------- checking and driving ------------------------------
    task automatic chk(input ctrl_t obs, input ctrl_t exp, input string tag);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s cyc=%0d state=%0d observed=%h expected=%h",
                   tag, cyc, exp.st, obs, exp);
        end
    endtask

    task automatic drainN(input int n);
        step_t s;
        int    done;
        done = 0;
        while (q.size() > 0 && done < n) begin
            s         = q.pop_front();
            mem_ready = s.rdy;
            @(negedge clk);
            cyc++;
            chk(obsJ, s.exp,   "jalOn");
            chk(obsN, s.expNj, "jalOff");
            @(posedge clk);
            #1;
            done++;
        end
    endtask

    task automatic runInstr(input logic [5:0] opc, input int fw, input int mw);
        op = opc;
        buildInstr(opc, fw, mw);
        drainN(1 << 30);
    endtask

    // ---------------- watchdog ------------------------------------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random sequence ------------------------
    initial begin
        logic [5:0] opList [12];
        logic [5:0] rop;
        int         fw, mw;
        opList = '{OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW,
                   OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_R};

        reset     = 1'b1;
        mem_ready = 1'b1;
        op        = OP_R;
        repeat (3) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk(obsJ, w0(4'd0), "resetJalOn");
            chk(obsN, w0(4'd0), "resetJalOff");
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        push1(1'b1, w0(4'd0));            // IDLE once, then FETCH

        runInstr(OP_R, 0, 0);
        runInstr(OP_LW, 0, 3);
        runInstr(OP_BNE, 0, 0);
        runInstr(OP_BEQ, 1, 0);
        runInstr(OP_ADDI, 20, 0);         // fetch timeout then retry
        runInstr(OP_JAL, 0, 0);
        runInstr(OP_J, 2, 0);
        runInstr(OP_SW, TMO, TMO);        // longest waits that still complete
        runInstr(OP_LW, 0, TMO + 1);      // read timeout
        runInstr(OP_SW, 0, TMO + 5);      // write timeout
        runInstr(6'b111111, 0, 0);
        runInstr(OP_ANDI, 0, 0);
        runInstr(OP_ORI, 0, 0);
        runInstr(OP_LUI, 0, 0);

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) rop = 6'($urandom_range(0, 63));
            else                           rop = opList[$urandom_range(0, 11)];
            fw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TMO - 1, TMO + 3))
                                             : int'($urandom_range(0, 2));
            mw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TMO - 1, TMO + 3))
                                             : int'($urandom_range(0, 3));
            runInstr(rop, fw, mw);
        end

        // Reset in the middle of a load's memory wait
        op = OP_LW;
        buildInstr(OP_LW, 0, 10);
        drainN(5);                        // FETCH, DECODE, MEM_ADDR, 2x MEM_RD
        q.delete();
        reset     = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk(obsJ, memW(1'b1), "resetMidWait");
        @(posedge clk);
        #1;
        reset = 1'b0;
        push1(rnd1(), w0(4'd0));
        runInstr(OP_R, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
